// File: rtl/path_metric_argbest.sv
// Pipelined arg-min / arg-max over N_STATES packed unsigned path metrics.
// One registered comparator-tree level per cycle; a tie always goes to the lower state index.
module path_metric_argbest #(
    parameter int N_STATES = 64,
    parameter int METRIC_W = 7
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          in_valid,
    input  logic                          find_min,
    input  logic [N_STATES*METRIC_W-1:0]  metrics,
    output logic                          out_valid,
    output logic [$clog2(N_STATES)-1:0]   best_index,
    output logic [METRIC_W-1:0]           best_metric,
    output logic                          busy
);
    localparam int IDX_W  = $clog2(N_STATES);
    localparam int LEVELS = $clog2(N_STATES);
    localparam int NODES  = 2 * N_STATES;

    // Heap numbering: node 1 is the root, node n has children 2n (lower index) and 2n+1;
    // leaves N_STATES..2*N_STATES-1 carry states 0..N_STATES-1 straight from the input.
    logic [METRIC_W-1:0] node_met [1:NODES-1];
    logic [IDX_W-1:0]    node_idx [1:NODES-1];
    logic [LEVELS:0]     vld_at;
    logic [LEVELS-1:0]   mode_at;

    assign vld_at[0]  = in_valid;
    assign mode_at[0] = find_min;

    for (genvar k = 0; k < N_STATES; k++) begin : g_leaf
        assign node_met[N_STATES+k] = metrics[k*METRIC_W +: METRIC_W];
        assign node_idx[N_STATES+k] = IDX_W'(k);
    end

    for (genvar lv = 1; lv <= LEVELS; lv++) begin : g_level
        logic vld_q;
        logic load;

        assign load       = vld_at[lv-1] & ~flush;
        assign vld_at[lv] = vld_q;

        // Stage valid: dropped by flush, otherwise follows the previous stage
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q <= 1'b0;
            end else if (flush) begin
                vld_q <= 1'b0;
            end else begin
                vld_q <= vld_at[lv-1];
            end
        end

        // The final level has no consumer for the mode, so it is not stored there
        if (lv < LEVELS) begin : g_mode
            logic mode_q;

            // Mode travels alongside its own sample
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    mode_q <= 1'b0;
                end else if (load) begin
                    mode_q <= mode_at[lv-1];
                end else begin
                    mode_q <= mode_q;
                end
            end

            assign mode_at[lv] = mode_q;
        end

        for (genvar j = 0; j < (N_STATES >> lv); j++) begin : g_node
            localparam int NODE = (N_STATES >> lv) + j;
            logic [METRIC_W-1:0] met_q;
            logic [IDX_W-1:0]    idx_q;
            logic                right_wins;

            // Right child must be strictly better, so equal metrics keep the lower index
            assign right_wins = mode_at[lv-1] ? (node_met[2*NODE+1] < node_met[2*NODE])
                                              : (node_met[2*NODE+1] > node_met[2*NODE]);

            // Node winner register, loaded only when a live sample arrives
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    met_q <= '0;
                    idx_q <= '0;
                end else if (load) begin
                    met_q <= right_wins ? node_met[2*NODE+1] : node_met[2*NODE];
                    idx_q <= right_wins ? node_idx[2*NODE+1] : node_idx[2*NODE];
                end else begin
                    met_q <= met_q;
                    idx_q <= idx_q;
                end
            end

            assign node_met[NODE] = met_q;
            assign node_idx[NODE] = idx_q;
        end
    end

    assign out_valid   = vld_at[LEVELS];
    assign best_index  = node_idx[1];
    assign best_metric = node_met[1];
    assign busy        = |vld_at[LEVELS:1];

endmodule

// File: tb/tb_path_metric_argbest.sv
// Bench for path_metric_argbest: three instances (default, 2x4, 128x9) driven together and
// scored every cycle against a linear-scan argmin/argmax model with lowest-index tie-break.
module tb_path_metric_argbest;
    localparam int ND = 3;
    localparam int NS  [ND] = '{64, 2, 128};
    localparam int MW  [ND] = '{7, 4, 9};
    localparam int LAT [ND] = '{6, 1, 7};

    typedef struct {
        int due;
        int idx;
        int met;
        int lit_idx;
        int lit_met;
    } exp_t;

    logic clk = 1'b0;
    logic rst, flush, in_valid, find_min;
    logic [64*7-1:0]  metrics0;
    logic [2*4-1:0]   metrics1;
    logic [128*9-1:0] metrics2;
    logic ov0, ov1, ov2, bz0, bz1, bz2;
    logic [5:0] bi0;
    logic [0:0] bi1;
    logic [6:0] bi2;
    logic [6:0] bm0;
    logic [3:0] bm1;
    logic [8:0] bm2;

    int   mv [ND][128];
    exp_t q [ND][$];
    int   last_idx [ND];
    int   last_met [ND];
    int   cyc = 0;
    int   nvec = 0;
    int   nfail = 0;
    int   lit_idx = -1;
    int   lit_met = -1;

    path_metric_argbest u_dut0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .find_min(find_min),
        .metrics(metrics0), .out_valid(ov0), .best_index(bi0), .best_metric(bm0), .busy(bz0)
    );
    path_metric_argbest #(.N_STATES(2), .METRIC_W(4)) u_dut1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .find_min(find_min),
        .metrics(metrics1), .out_valid(ov1), .best_index(bi1), .best_metric(bm1), .busy(bz1)
    );
    path_metric_argbest #(.N_STATES(128), .METRIC_W(9)) u_dut2 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .find_min(find_min),
        .metrics(metrics2), .out_valid(ov2), .best_index(bi2), .best_metric(bm2), .busy(bz2)
    );

    always #5 clk = ~clk;

    task automatic check(input int d, input string nm, input logic [31:0] act, input logic [31:0] want);
        nvec++;
        if (act !== want) begin
            nfail++;
            $display("FAIL dut%0d %s: got %0d, expected %0d (cycle %0d)", d, nm, act, want, cyc);
        end
    endtask

    function automatic void best(input int d, input logic fm, output int bi, output int bm);
        bi = 0;
        bm = mv[d][0];
        for (int k = 1; k < NS[d]; k++) begin
            if (fm ? (mv[d][k] < bm) : (mv[d][k] > bm)) begin
                bi = k;
                bm = mv[d][k];
            end
        end
    endfunction

    function automatic void dut_out(input int d, output logic [31:0] ov, output logic [31:0] bz,
                                    output logic [31:0] bi, output logic [31:0] bm);
        case (d)
            0: begin ov = 32'(ov0); bz = 32'(bz0); bi = 32'(bi0); bm = 32'(bm0); end
            1: begin ov = 32'(ov1); bz = 32'(bz1); bi = 32'(bi1); bm = 32'(bm1); end
            default: begin ov = 32'(ov2); bz = 32'(bz2); bi = 32'(bi2); bm = 32'(bm2); end
        endcase
    endfunction

    // Reference model: every accepted sample becomes one expected result LAT cycles later
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                for (int d = 0; d < ND; d++) begin
                    q[d].delete();
                    last_idx[d] = 0;
                    last_met[d] = 0;
                end
            end else begin
                cyc++;
                if (flush) begin
                    for (int d = 0; d < ND; d++) q[d].delete();
                end else if (in_valid) begin
                    for (int d = 0; d < ND; d++) begin
                        best(d, find_min, e.idx, e.met);
                        e.due     = cyc + LAT[d] - 1;
                        e.lit_idx = (d == 0) ? lit_idx : -1;
                        e.lit_met = (d == 0) ? lit_met : -1;
                        q[d].push_back(e);
                    end
                end
            end
        end
    end

    // Compare process: all outputs of all instances, every cycle, on the falling edge
    initial begin
        logic        e_ov;
        logic [31:0] ov, bz, bi, bm;
        exp_t        e;
        forever begin
            @(negedge clk);
            for (int d = 0; d < ND; d++) begin
                dut_out(d, ov, bz, bi, bm);
                e_ov = (q[d].size() > 0) && (q[d][0].due == cyc);
                check(d, "busy", bz, 32'(q[d].size() > 0));
                check(d, "out_valid", ov, 32'(e_ov));
                if (e_ov) begin
                    e = q[d].pop_front();
                    last_idx[d] = e.idx;
                    last_met[d] = e.met;
                    if (e.lit_idx >= 0) begin
                        check(d, "model_pin_index", e.idx, e.lit_idx);
                        check(d, "model_pin_metric", e.met, e.lit_met);
                    end
                end
                check(d, "best_index", bi, last_idx[d]);
                check(d, "best_metric", bm, last_met[d]);
            end
        end
    end

    task automatic pack();
        for (int k = 0; k < 64; k++)  metrics0[k*7 +: 7] = 7'(mv[0][k]);
        for (int k = 0; k < 2; k++)   metrics1[k*4 +: 4] = 4'(mv[1][k]);
        for (int k = 0; k < 128; k++) metrics2[k*9 +: 9] = 9'(mv[2][k]);
    endtask

    task automatic rand_vec(input int d, input int maxv);
        for (int k = 0; k < NS[d]; k++) mv[d][k] = int'($urandom_range(32'(maxv)));
    endtask

    task automatic set_all(input int v);
        for (int k = 0; k < 64; k++) mv[0][k] = v;
    endtask

    // One cycle of stimulus; the two sweep instances always get fresh random vectors
    task automatic apply(input logic v, input logic fm, input int li, input int lm);
        for (int d = 1; d < ND; d++)
            rand_vec(d, ($urandom_range(1) == 1) ? ((1 << MW[d]) - 1) : 3);
        pack();
        in_valid = v;
        find_min = fm;
        lit_idx  = li;
        lit_met  = lm;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) apply(1'b0, 1'b0, -1, -1);
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        find_min = 1'b0;
        for (int d = 0; d < ND; d++) rand_vec(d, 0);
        pack();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        set_all(0);
        mv[0][37] = 100;
        apply(1'b1, 1'b0, 37, 100);
        idle(8);

        set_all(127);
        mv[0][5] = 3;
        mv[0][50] = 3;
        apply(1'b1, 1'b1, 5, 3);
        set_all(9);
        apply(1'b1, 1'b0, 0, 9);
        idle(8);

        for (int k = 0; k < 6; k++) begin
            set_all(64);
            mv[0][k*10] = 0;
            mv[0][k*10+1] = 127;
            if (k % 2 == 0) apply(1'b1, 1'b1, k*10, 0);
            else            apply(1'b1, 1'b0, k*10+1, 127);
        end
        idle(8);

        for (int s = 0; s < 3; s++) begin
            rand_vec(0, 127);
            if (s == 2) flush = 1'b1;
            apply(1'b1, 1'($urandom_range(1)), -1, -1);
        end
        flush = 1'b0;
        idle(10);

        for (int s = 0; s < 3; s++) begin
            rand_vec(0, 127);
            apply(1'b1, 1'($urandom_range(1)), -1, -1);
        end
        rand_vec(0, 127);
        pack();
        in_valid = 1'b1;
        @(posedge clk);
        #2 rst = 1'b1;
        in_valid = 1'b0;
        #1;
        check(0, "rst_out_valid", 32'(ov0), 32'd0);
        check(0, "rst_busy", 32'(bz0), 32'd0);
        check(0, "rst_best_index", 32'(bi0), 32'd0);
        check(0, "rst_best_metric", 32'(bm0), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        set_all(0);
        mv[0][37] = 100;
        apply(1'b1, 1'b0, 37, 100);
        idle(20);

        for (int s = 0; s < 400; s++) begin
            flush = ($urandom_range(99) < 3);
            rand_vec(0, ($urandom_range(1) == 1) ? 127 : 3);
            apply(1'($urandom_range(99) < 70), 1'($urandom_range(1)), -1, -1);
        end
        flush = 1'b0;
        idle(10);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/path_metric_argbest.md
Name: path_metric_argbest

Overview:
- Pipelined, parametrised arg-best finder for Viterbi path metrics.
- Takes N_STATES packed unsigned metrics per sample and returns the winning state index and its metric.
- Per-sample mode selects minimum or maximum.
- Fully streaming: one new metric vector per clock, one pipeline register per comparator-tree level; feeds the traceback/normalisation logic of the convolutional decoder.

Parameters:
- N_STATES, 64, number of trellis states; power of two, >= 2.
- METRIC_W, 7, width of each unsigned path metric.
- IDX_W, $clog2(N_STATES), index width (derived; not overridden).
- LEVELS, $clog2(N_STATES), tree depth and latency (derived).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of all in-flight valids.
- in_valid  in  1  metric vector valid this cycle.
- find_min  in  1  1 = select minimum, 0 = select maximum; sampled with in_valid.
- metrics  in  N_STATES*METRIC_W  packed metrics; state k at bits [(k+1)*METRIC_W-1 : k*METRIC_W].
- out_valid  out  1  result valid, 1-cycle pulse per input sample.
- best_index  out  IDX_W  winning state index.
- best_metric  out  METRIC_W  winning metric value.
- busy  out  1  OR of all pipeline stage valids.

Behaviour:
- Reset (async, rst=1): all stage valid bits, out_valid and busy go to 0; best_index and best_metric go to 0. Deassertion takes effect on the next clk edge.
- Tree structure:
  - Level 1 compares pairs (2j, 2j+1) straight from metrics.
  - Level L compares pairs of level L-1 winners.
  - Each node carries (metric, index, mode).
  - The result of every level is registered, so latency is exactly LEVELS cycles: in_valid at edge t gives out_valid at edge t+LEVELS (6 for defaults).
- Compare rule:
  - Unsigned metric comparison.
  - Max mode: the right (higher-index) node wins only if strictly greater.
  - Min mode: the right node wins only if strictly less.
  - On a tie the lower index always wins, at every level including the last.
- Mode is pipelined with its sample. Changing find_min between consecutive samples must not corrupt either result.
- Stage data registers load only when the preceding stage valid is 1; otherwise they hold. After the final sample, best_index and best_metric therefore hold the last valid result indefinitely while out_valid=0.
- No backpressure: a sample is accepted every cycle that in_valid=1. Back-to-back samples produce back-to-back out_valid pulses in order.
- flush=1 at an edge clears every stage valid and out_valid; data registers are untouched.
  - If in_valid=1 in the same cycle, flush wins and the sample is dropped.
  - busy=0 the cycle after the flush.
- rst asserted mid-stream discards all in-flight samples. No out_valid may appear for samples accepted before reset.
- Width rules: no arithmetic, only compare and select. best_metric equals one of the input metrics bit-exactly, and best_index < N_STATES.
- busy=1 whenever any sample is in flight, including the cycle out_valid=1.

Test Plan:
- Defaults, max mode; metrics all 0 except state 37 = 100; single in_valid pulse at cycle 0 -> out_valid at cycle 6 only, best_index=37, best_metric=100.
- Min mode; all metrics 127 except states 5 and 50 = 3 -> best_index=5, best_metric=3 (lowest-index tie-break). Repeat in max mode with all metrics equal to 9 -> best_index=0, best_metric=9.
- Six back-to-back samples alternating find_min 1/0; vector k has state k*10 = 0 and state k*10+1 = 127, others 64 -> six consecutive out_valid pulses: min results give index k*10 with metric 0; max results give index k*10+1 with metric 127; order is preserved.
- Send 3 samples, assert flush at cycle 2 together with in_valid -> no out_valid ever; busy=0 at cycle 3. Afterwards best_index and best_metric keep their pre-flush values.
- Assert rst asynchronously at cycle 3 of a 4-sample burst, release at cycle 5 -> outputs go 0 immediately; no out_valid through cycle 20; a new sample at cycle 6 gives a correct result at cycle 12.
- Parameter sweep N_STATES=2, METRIC_W=4 (latency 1) and N_STATES=128, METRIC_W=9 (latency 7), random vectors compared against a behavioural argmin/argmax model with lowest-index tie-break.
